// File: rtl/lib_arbiter_pkg.sv
// Shared definitions for the AER readout path: event word layout, type codes
// and default widths.
package lib_arbiter_pkg;

    localparam int ADD_W_DEF = 4;
    localparam int TS_W_DEF  = 16;
    localparam int DEPTH_DEF = 8;
    localparam int EVT_W_DEF = 1 + TS_W_DEF + 2 * ADD_W_DEF;

    localparam logic EVT_PIXEL  = 1'b0;
    localparam logic EVT_TSWRAP = 1'b1;

    // Event word at default widths, MSB first: {type, ts, y, x}
    typedef struct packed {
        logic                 evt_type;
        logic [TS_W_DEF-1:0]  ts;
        logic [ADD_W_DEF-1:0] y;
        logic [ADD_W_DEF-1:0] x;
    } evt_word_t;

endpackage

// File: rtl/evt_fifo.sv
// First-word-fall-through event FIFO; the head word is presented whenever the
// FIFO holds data, and a write while full is taken only alongside a pop.
module evt_fifo #(
    parameter int W     = 25,
    parameter int DEPTH = 8
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_wr,
    input  logic [W-1:0] i_wr_data,
    input  logic         i_rd,
    output logic [W-1:0] o_rd_data,
    output logic         o_valid,
    output logic         o_full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;

    logic w_empty;
    logic w_pop;
    logic w_push;

    assign w_empty   = (r_count == '0);
    assign o_full    = (r_count == FULL_CNT);
    assign o_valid   = !w_empty;
    assign o_rd_data = r_mem[r_rptr];

    assign w_pop  = i_rd && !w_empty;
    assign w_push = i_wr && (!o_full || w_pop);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: contents are only visible through the count.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wptr] <= i_wr_data;
    end

endmodule

// File: rtl/aer_event_packer.sv
// Packs arbiter grants into timestamped AER words, inserts a marker on every
// timestamp wrap, and buffers both in a FWFT FIFO towards the consumer.
module aer_event_packer
    import lib_arbiter_pkg::*;
#(
    parameter int ADD_W = ADD_W_DEF,
    parameter int TS_W  = TS_W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int EVT_W = 1 + TS_W + 2 * ADD_W
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             active_i,
    input  logic [ADD_W-1:0] x_add_i,
    input  logic [ADD_W-1:0] y_add_i,
    output logic             stall_o,
    output logic             evt_valid_o,
    input  logic             evt_ready_i,
    output logic [EVT_W-1:0] evt_data_o,
    output logic [7:0]       drop_cnt_o,
    output logic             overflow_o
);

    logic [TS_W-1:0]  r_ts;
    logic [TS_W-1:0]  r_wrap_cnt;
    logic             r_cap_vld;
    logic [EVT_W-1:0] r_cap_data;
    logic             r_mk_pend;
    logic [7:0]       r_drop_cnt;
    logic             r_overflow;

    logic             w_full;
    logic             w_valid;
    logic             w_pop;
    logic             w_wrap;
    logic             w_mk_wr;
    logic             w_wr;
    logic             w_drop;
    logic [EVT_W-1:0] w_marker;
    logic [EVT_W-1:0] w_wr_data;

    assign w_pop    = w_valid && evt_ready_i;
    assign w_wrap   = (r_ts == {TS_W{1'b1}});
    assign w_marker = {EVT_TSWRAP, r_wrap_cnt, {(2 * ADD_W){1'b0}}};

    // Pixel events own the write port; the marker waits for an idle, non-full edge.
    assign w_mk_wr   = r_mk_pend && !r_cap_vld && !w_full;
    assign w_wr      = r_cap_vld || w_mk_wr;
    assign w_wr_data = r_cap_vld ? r_cap_data : w_marker;
    assign w_drop    = r_cap_vld && w_full && !w_pop;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_ts       <= '0;
            r_wrap_cnt <= '0;
            r_cap_vld  <= 1'b0;
            r_cap_data <= '0;
            r_mk_pend  <= 1'b0;
            r_drop_cnt <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_ts      <= r_ts + 1'b1;
            r_cap_vld <= active_i;
            if (active_i) begin
                r_cap_data <= {EVT_PIXEL, r_ts, y_add_i, x_add_i};
            end

            if (w_wrap) begin
                r_wrap_cnt <= r_wrap_cnt + 1'b1;
                r_mk_pend  <= 1'b1;
                // A second wrap before the first marker got out loses that marker.
                if (r_mk_pend && !w_mk_wr) r_overflow <= 1'b1;
            end else if (w_mk_wr) begin
                r_mk_pend <= 1'b0;
            end

            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end
    end

    evt_fifo #(
        .W     (EVT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk     (clk_i),
        .i_reset   (reset_i),
        .i_wr      (w_wr),
        .i_wr_data (w_wr_data),
        .i_rd      (evt_ready_i),
        .o_rd_data (evt_data_o),
        .o_valid   (w_valid),
        .o_full    (w_full)
    );

    assign evt_valid_o = w_valid;
    assign stall_o     = w_full;
    assign drop_cnt_o  = r_drop_cnt;
    assign overflow_o  = r_overflow;

endmodule

// File: tb/tb_aer_event_packer.sv
// Directed and randomised checks of aer_event_packer with a queue scoreboard;
// a second instance with a 4-bit timestamp exercises the wrap marker.
module tb_aer_event_packer;

    localparam int ADD_W   = 4;
    localparam int TS_W    = 16;
    localparam int DEPTH   = 8;
    localparam int EVT_W   = 1 + TS_W + 2 * ADD_W;
    localparam int TS_W_S  = 4;
    localparam int EVT_W_S = 1 + TS_W_S + 2 * ADD_W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset, active, ready;
    logic [ADD_W-1:0] x, y;
    logic             stall, valid, ovf;
    logic [EVT_W-1:0] data;
    logic [7:0]       drop;

    logic               reset_w, active_w, ready_w;
    logic [ADD_W-1:0]   x_w, y_w;
    logic               stall_w, valid_w, ovf_w;
    logic [EVT_W_S-1:0] data_w;
    logic [7:0]         drop_w;

    aer_event_packer #(.ADD_W(ADD_W), .TS_W(TS_W), .DEPTH(DEPTH), .EVT_W(EVT_W)) dut (
        .clk_i(clk), .reset_i(reset), .active_i(active), .x_add_i(x), .y_add_i(y),
        .stall_o(stall), .evt_valid_o(valid), .evt_ready_i(ready), .evt_data_o(data),
        .drop_cnt_o(drop), .overflow_o(ovf)
    );

    aer_event_packer #(.ADD_W(ADD_W), .TS_W(TS_W_S), .DEPTH(DEPTH), .EVT_W(EVT_W_S)) dut_w (
        .clk_i(clk), .reset_i(reset_w), .active_i(active_w), .x_add_i(x_w), .y_add_i(y_w),
        .stall_o(stall_w), .evt_valid_o(valid_w), .evt_ready_i(ready_w), .evt_data_o(data_w),
        .drop_cnt_o(drop_w), .overflow_o(ovf_w)
    );

    int tests = 0;
    int fails = 0;

    logic [EVT_W-1:0]   sb_q[$];
    logic [EVT_W_S-1:0] sb_w[$];

    // Reference timestamps: zero after a reset edge, +1 on every other edge.
    logic [TS_W-1:0]   m_ts;
    logic [TS_W_S-1:0] m_ts_w;
    always @(posedge clk) m_ts   <= reset   ? '0 : m_ts + 1'b1;
    always @(posedge clk) m_ts_w <= reset_w ? '0 : m_ts_w + 1'b1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [ADD_W-1:0] xx, input logic [ADD_W-1:0] yy, input bit keep);
        active = 1'b1;
        x      = xx;
        y      = yy;
        if (keep) sb_q.push_back({1'b0, m_ts, yy, xx});
    endtask

    logic [TS_W-1:0] last_ts;
    bit              mono_vld = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            mono_vld = 1'b0;
        end else if (valid && ready) begin
            check("sb_expected_evt", 64'(sb_q.size() != 0), 1);
            if (sb_q.size() != 0) check("sb_data", data, sb_q.pop_front());
            if (mono_vld) check("ts_monotonic", 64'(data[EVT_W-2 -: TS_W] > last_ts), 1);
            last_ts  = data[EVT_W-2 -: TS_W];
            mono_vld = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (!reset_w && valid_w && ready_w) begin
            check("sbw_expected_evt", 64'(sb_w.size() != 0), 1);
            if (sb_w.size() != 0) check("sbw_data", data_w, sb_w.pop_front());
        end
    end

    task automatic drain(input string tag);
        ready = 1'b1;
        for (int i = 0; i < 40 && sb_q.size() != 0; i++) tick();
        tick();
        check(tag, sb_q.size(), 0);
        check({tag, "_valid"}, valid, 0);
        ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        int cyc;

        reset = 1'b1; active = 1'b0; ready = 1'b0; x = '0; y = '0;
        reset_w = 1'b1; active_w = 1'b0; ready_w = 1'b0; x_w = '0; y_w = '0;
        repeat (3) tick();
        check("rst_valid", valid, 0);
        check("rst_stall", stall, 0);
        check("rst_drop", drop, 0);
        check("rst_ovf", ovf, 0);
        reset = 1'b0;

        // Single event at ts=10
        for (int i = 0; i < 100 && m_ts != 16'd10; i++) tick();
        send(4'd3, 4'd5, 1'b1);
        tick();
        active = 1'b0;
        check("first_valid_early", valid, 0);
        tick();
        check("first_valid", valid, 1);
        check("first_data", data, {1'b0, 16'd10, 4'd5, 4'd3});
        tick();
        check("first_hold", data, {1'b0, 16'd10, 4'd5, 4'd3});
        drain("first_drain");

        // Nine events into a stalled consumer
        for (int i = 0; i < 9; i++) begin
            send(4'(i), 4'(8 - i), i < 8);
            tick();
            if (i == 7) check("fill_stall_7", stall, 0);
        end
        check("fill_stall_8", stall, 1);
        check("fill_drop_pre", drop, 0);
        active = 1'b0;
        tick();
        check("fill_drop", drop, 1);
        check("fill_ovf", ovf, 1);
        check("fill_stall", stall, 1);

        // Full FIFO: pop and write on the same edge
        send(4'hA, 4'hB, 1'b1);
        tick();
        active = 1'b0;
        ready  = 1'b1;
        tick();
        ready = 1'b0;
        check("full_swap_stall", stall, 1);
        check("full_swap_drop", drop, 1);
        drain("full_swap_drain");

        // Reset with five buffered events; active on the reset edge is ignored
        for (int i = 0; i < 5; i++) begin
            send(4'(i + 1), 4'(i + 2), 1'b1);
            tick();
        end
        active = 1'b0;
        repeat (2) tick();
        check("pre_rst_valid", valid, 1);
        reset = 1'b1;
        sb_q.delete();
        active = 1'b1; x = 4'd7; y = 4'd7;
        tick();
        reset = 1'b0;
        send(4'd1, 4'd2, 1'b1);
        check("mid_rst_valid", valid, 0);
        check("mid_rst_drop", drop, 0);
        check("mid_rst_ovf", ovf, 0);
        check("mid_rst_stall", stall, 0);
        tick();
        active = 1'b0;
        check("rst_edge_ignored", valid, 0);
        tick();
        check("post_rst_valid", valid, 1);
        check("post_rst_data_ts0", data, {1'b0, 16'd0, 4'd2, 4'd1});
        drain("post_rst_drain");

        // Random consumer back-pressure over 1000 events, kept below overflow
        sent = 0;
        cyc  = 0;
        while (sent < 1000 && cyc < 20000) begin
            ready = 1'($urandom_range(0, 1));
            if (sb_q.size() < DEPTH && $urandom_range(0, 2) != 0) begin
                send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b1);
                sent++;
            end else begin
                active = 1'b0;
            end
            tick();
            cyc++;
        end
        active = 1'b0;
        check("rand_sent", sent, 1000);
        drain("rand_drain");
        check("rand_drop", drop, 0);
        check("rand_ovf", ovf, 0);

        // 4-bit timestamp: continuous events across one wrap, then the marker
        repeat (2) tick();
        reset_w = 1'b0;
        ready_w = 1'b1;
        for (int i = 0; i < 40 && m_ts_w != 4'd4; i++) tick();
        for (int i = 0; i < 16; i++) begin
            active_w = 1'b1;
            x_w      = 4'(i);
            y_w      = 4'(15 - i);
            sb_w.push_back({1'b0, m_ts_w, 4'(15 - i), 4'(i)});
            tick();
        end
        active_w = 1'b0;
        sb_w.push_back({1'b1, 4'd1, 4'd0, 4'd0});
        for (int i = 0; i < 20 && sb_w.size() != 0; i++) tick();
        check("wrap_all_seen", sb_w.size(), 0);
        tick();
        check("wrap_valid_after", valid_w, 0);
        check("wrap_ovf", ovf_w, 0);
        check("wrap_drop", drop_w, 0);
        reset_w = 1'b1;
        ready_w = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
